// File: rtl/avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module : avalon_arbiter
// Shares one Avalon-MM master between instruction-fetch and data requesters.
// Rev    : 1.0
// ============================================================================
module avalon_arbiter #(
  parameter int DATA_PRIORITY = 1,
  parameter int MAX_WAIT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] av_address,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  output logic [3:0]  av_byteenable,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam int c_cnt_w = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [c_cnt_w-1:0] c_wait_limit = c_cnt_w'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t             r_state, w_state;
  logic               r_last_d, w_last_d;
  logic [c_cnt_w-1:0] r_cnt, w_cnt;
  logic [31:0]        r_av_address, w_av_address;
  logic               r_av_read, w_av_read;
  logic               r_av_write, w_av_write;
  logic [31:0]        r_av_writedata, w_av_writedata;
  logic [3:0]         r_av_byteenable, w_av_byteenable;
  logic [31:0]        r_i_rdata, w_i_rdata;
  logic [31:0]        r_d_rdata, w_d_rdata;
  logic               r_i_ack, w_i_ack;
  logic               r_d_ack, w_d_ack;
  logic               r_timeout, w_timeout;
  logic               w_pick_d;
  logic               w_unused;

  // Avalon addresses are word-aligned; the byte offset is carried by byteenable.
  assign w_unused = ^{i_addr[1:0], d_addr[1:0]};

  always_comb begin
    w_state         = r_state;
    w_last_d        = r_last_d;
    w_cnt           = r_cnt;
    w_av_address    = r_av_address;
    w_av_read       = r_av_read;
    w_av_write      = r_av_write;
    w_av_writedata  = r_av_writedata;
    w_av_byteenable = r_av_byteenable;
    w_i_rdata       = r_i_rdata;
    w_d_rdata       = r_d_rdata;
    w_i_ack         = 1'b0;
    w_d_ack         = 1'b0;
    w_timeout       = 1'b0;

    // On a tie, round-robin hands the grant to whichever side did not win last.
    w_pick_d = d_req;
    if (i_req && d_req)
      w_pick_d = (DATA_PRIORITY != 0) ? 1'b1 : !r_last_d;

    case (r_state)
      IDLE: begin
        w_av_read  = 1'b0;
        w_av_write = 1'b0;
        if (i_req || d_req) begin
          w_cnt    = '0;
          w_last_d = w_pick_d;
          if (w_pick_d) begin
            w_state         = GRANT_D;
            w_av_address    = {d_addr[31:2], 2'b00};
            w_av_read       = !d_we;
            w_av_write      = d_we;
            w_av_writedata  = d_wdata;
            w_av_byteenable = d_we ? d_be : 4'hF;
          end else begin
            w_state         = GRANT_I;
            w_av_address    = {i_addr[31:2], 2'b00};
            w_av_read       = 1'b1;
            w_av_byteenable = 4'hF;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (!av_waitrequest) begin
          w_av_read  = 1'b0;
          w_av_write = 1'b0;
          w_state    = ACK;
          if (r_state == GRANT_I) begin
            w_i_rdata = av_readdata;
            w_i_ack   = 1'b1;
          end else begin
            if (r_av_read)
              w_d_rdata = av_readdata;
            w_d_ack = 1'b1;
          end
        end else if ((MAX_WAIT != 0) && (r_cnt == c_wait_limit)) begin
          w_av_read  = 1'b0;
          w_av_write = 1'b0;
          w_state    = ACK;
          w_timeout  = 1'b1;
          if (r_state == GRANT_I) begin
            w_i_rdata = '0;
            w_i_ack   = 1'b1;
          end else begin
            w_d_rdata = '0;
            w_d_ack   = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_last_d        <= 1'b1;
      r_cnt           <= '0;
      r_av_address    <= '0;
      r_av_read       <= 1'b0;
      r_av_write      <= 1'b0;
      r_av_writedata  <= '0;
      r_av_byteenable <= '0;
      r_i_rdata       <= '0;
      r_d_rdata       <= '0;
      r_i_ack         <= 1'b0;
      r_d_ack         <= 1'b0;
      r_timeout       <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_last_d        <= w_last_d;
      r_cnt           <= w_cnt;
      r_av_address    <= w_av_address;
      r_av_read       <= w_av_read;
      r_av_write      <= w_av_write;
      r_av_writedata  <= w_av_writedata;
      r_av_byteenable <= w_av_byteenable;
      r_i_rdata       <= w_i_rdata;
      r_d_rdata       <= w_d_rdata;
      r_i_ack         <= w_i_ack;
      r_d_ack         <= w_d_ack;
      r_timeout       <= w_timeout;
    end
  end

  assign av_address    = r_av_address;
  assign av_read       = r_av_read;
  assign av_write      = r_av_write;
  assign av_writedata  = r_av_writedata;
  assign av_byteenable = r_av_byteenable;
  assign i_rdata       = r_i_rdata;
  assign i_ack         = r_i_ack;
  assign d_rdata       = r_d_rdata;
  assign d_ack         = r_d_ack;
  assign timeout_err   = r_timeout;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_avalon_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_avalon_arbiter
// Drives transfer rounds into two arbiter instances (data-priority and
// round-robin) and compares them to a transaction-timing reference model.
// Rev    : 1.0
// ============================================================================
module tb_avalon_arbiter;

  localparam int MAX_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        i_req, d_req, d_we, av_waitrequest;
  logic [31:0] i_addr, d_addr, d_wdata, av_readdata;
  logic [3:0]  d_be;

  logic [31:0] pa_i_rdata, pa_d_rdata, pa_av_address, pa_av_writedata;
  logic        pa_i_ack, pa_d_ack, pa_av_read, pa_av_write, pa_busy, pa_timeout;
  logic [3:0]  pa_av_be;
  logic [31:0] rr_i_rdata, rr_d_rdata, rr_av_address, rr_av_writedata;
  logic        rr_i_ack, rr_d_ack, rr_av_read, rr_av_write, rr_busy, rr_timeout;
  logic [3:0]  rr_av_be;

  avalon_arbiter #(.DATA_PRIORITY(1), .MAX_WAIT(MAX_W)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(pa_i_rdata), .i_ack(pa_i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(pa_d_rdata), .d_ack(pa_d_ack),
    .av_address(pa_av_address), .av_read(pa_av_read), .av_write(pa_av_write),
    .av_writedata(pa_av_writedata), .av_byteenable(pa_av_be),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .busy(pa_busy), .timeout_err(pa_timeout)
  );

  avalon_arbiter #(.DATA_PRIORITY(0), .MAX_WAIT(MAX_W)) dut_rr (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(rr_i_rdata), .i_ack(rr_i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(rr_d_rdata), .d_ack(rr_d_ack),
    .av_address(rr_av_address), .av_read(rr_av_read), .av_write(rr_av_write),
    .av_writedata(rr_av_writedata), .av_byteenable(rr_av_be),
    .av_waitrequest(av_waitrequest), .av_readdata(av_readdata),
    .busy(rr_busy), .timeout_err(rr_timeout)
  );

  // Both instances see the same stimulus; the bench follows one of them at a time.
  bit sel_rr = 1'b0;
  logic [31:0] obs_i_rdata, obs_d_rdata, obs_av_address, obs_av_writedata;
  logic        obs_i_ack, obs_d_ack, obs_av_read, obs_av_write, obs_busy, obs_timeout;
  logic [3:0]  obs_av_be;
  assign obs_i_rdata      = sel_rr ? rr_i_rdata      : pa_i_rdata;
  assign obs_d_rdata      = sel_rr ? rr_d_rdata      : pa_d_rdata;
  assign obs_av_address   = sel_rr ? rr_av_address   : pa_av_address;
  assign obs_av_writedata = sel_rr ? rr_av_writedata : pa_av_writedata;
  assign obs_i_ack        = sel_rr ? rr_i_ack        : pa_i_ack;
  assign obs_d_ack        = sel_rr ? rr_d_ack        : pa_d_ack;
  assign obs_av_read      = sel_rr ? rr_av_read      : pa_av_read;
  assign obs_av_write     = sel_rr ? rr_av_write     : pa_av_write;
  assign obs_busy         = sel_rr ? rr_busy         : pa_busy;
  assign obs_timeout      = sel_rr ? rr_timeout      : pa_timeout;
  assign obs_av_be        = sel_rr ? rr_av_be        : pa_av_be;

  int checks = 0;
  int errors = 0;

  // Reference state: who won last, and what each requester last received.
  bit          m_last_d;
  logic [31:0] m_i_rdata, m_d_rdata;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; av_waitrequest = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; av_readdata = '0;
  endtask

  task automatic model_reset();
    m_last_d = 1'b1; m_i_rdata = '0; m_d_rdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // One round: up to one transfer per requester. The model schedules grants from
  // arrival times and wait counts, then every cycle's outputs are compared.
  task automatic run_round(input bit has_i, input bit has_d, input int ti, input int td,
                           input int wi, input int wd, input logic [31:0] ia,
                           input logic [31:0] da, input bit dwe, input logic [31:0] dwd,
                           input logic [3:0] dbe, input logic [31:0] rdi,
                           input logic [31:0] rdd);
    bit          pend [2];
    int          arr [2], w [2], g [2], len [2], ack [2];
    bit          to [2];
    logic [31:0] cap [2];
    int          t, a, last, pick, k;
    bit          ci, cd, rd_exp, wr_exp, busy_exp, present;
    logic [2:0]  ack_exp;
    logic [31:0] addr_exp;
    logic [3:0]  be_exp;

    pend[0] = has_i; pend[1] = has_d;
    arr[0] = ti; arr[1] = td; w[0] = wi; w[1] = wd;
    for (int x = 0; x < 2; x++) begin
      g[x] = -100; ack[x] = -100; len[x] = 0; to[x] = 1'b0; cap[x] = '0;
    end
    t = 0; last = 0;
    for (int n = 0; n < 2; n++) begin
      if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) a = (arr[0] < arr[1]) ? arr[0] : arr[1];
        else a = pend[0] ? arr[0] : arr[1];
        if (a > t) t = a;
        ci = pend[0] && (arr[0] <= t);
        cd = pend[1] && (arr[1] <= t);
        if (ci && cd) pick = sel_rr ? (m_last_d ? 0 : 1) : 1;
        else pick = cd ? 1 : 0;
        m_last_d  = (pick == 1);
        to[pick]  = (w[pick] > MAX_W);
        len[pick] = to[pick] ? MAX_W + 1 : w[pick] + 1;
        g[pick]   = t;
        ack[pick] = t + 1 + len[pick];
        pend[pick] = 1'b0;
        t    = ack[pick] + 1;
        last = ack[pick];
      end
    end

    i_addr = ia; d_addr = da; d_we = dwe; d_wdata = dwd; d_be = dbe;
    for (int c = 0; c <= last; c++) begin
      i_req = has_i && (c >= ti) && (c <= ack[0]);
      d_req = has_d && (c >= td) && (c <= ack[1]);
      av_waitrequest = 1'($urandom_range(0, 1));
      av_readdata    = $urandom;
      rd_exp = 1'b0; wr_exp = 1'b0; busy_exp = 1'b0; ack_exp = '0;
      addr_exp = '0; be_exp = '0;
      for (int x = 0; x < 2; x++) begin
        present = (x == 0) ? has_i : has_d;
        if (present) begin
          if (c > g[x] && c <= ack[x]) busy_exp = 1'b1;
          if (c > g[x] && c < ack[x]) begin
            k = c - g[x] - 1;
            av_waitrequest = (k < w[x]);
            if (k == w[x]) begin
              av_readdata = (x == 0) ? rdi : rdd;
              cap[x] = av_readdata;
            end
            addr_exp = ((x == 0) ? ia : da) & 32'hFFFF_FFFC;
            be_exp   = (x == 1 && dwe) ? dbe : 4'hF;
            rd_exp   = (x == 0) || !dwe;
            wr_exp   = (x == 1) && dwe;
          end
          if (c == ack[x]) begin
            ack_exp[x] = 1'b1;
            if (to[x]) ack_exp[2] = 1'b1;
            if (x == 0) m_i_rdata = to[0] ? 32'h0 : cap[0];
            else if (to[1]) m_d_rdata = 32'h0;
            else if (!dwe) m_d_rdata = cap[1];
          end
        end
      end

      checks++;
      if ({obs_av_read, obs_av_write} !== {rd_exp, wr_exp}) begin
        errors++;
        $display("FAIL strobes c=%0d: got read/write=%b%b, want %b%b",
                 c, obs_av_read, obs_av_write, rd_exp, wr_exp);
      end
      if (rd_exp || wr_exp) begin
        checks++;
        if (obs_av_address !== addr_exp || obs_av_be !== be_exp) begin
          errors++;
          $display("FAIL addr_be c=%0d: got %h/%h, want %h/%h",
                   c, obs_av_address, obs_av_be, addr_exp, be_exp);
        end
        if (wr_exp) begin
          checks++;
          if (obs_av_writedata !== dwd) begin
            errors++;
            $display("FAIL writedata c=%0d: got %h, want %h", c, obs_av_writedata, dwd);
          end
        end
      end
      checks++;
      if ({obs_timeout, obs_d_ack, obs_i_ack} !== ack_exp) begin
        errors++;
        $display("FAIL acks c=%0d: got err/d/i=%b, want %b",
                 c, {obs_timeout, obs_d_ack, obs_i_ack}, ack_exp);
      end
      checks++;
      if (obs_busy !== busy_exp) begin
        errors++;
        $display("FAIL busy c=%0d: got %b, want %b", c, obs_busy, busy_exp);
      end
      if (ack_exp[0]) begin
        checks++;
        if (obs_i_rdata !== m_i_rdata) begin
          errors++;
          $display("FAIL i_rdata c=%0d: got %h, want %h", c, obs_i_rdata, m_i_rdata);
        end
      end
      if (ack_exp[1]) begin
        checks++;
        if (obs_d_rdata !== m_d_rdata) begin
          errors++;
          $display("FAIL d_rdata c=%0d: got %h, want %h", c, obs_d_rdata, m_d_rdata);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({pa_av_address, pa_av_read, pa_av_write, pa_av_writedata, pa_av_be, pa_i_rdata,
         pa_i_ack, pa_d_rdata, pa_d_ack, pa_busy, pa_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_prio: outputs not all zero (addr=%h busy=%b)",
               pa_av_address, pa_busy);
    end
    checks++;
    if ({rr_av_address, rr_av_read, rr_av_write, rr_av_writedata, rr_av_be, rr_i_rdata,
         rr_i_ack, rr_d_rdata, rr_d_ack, rr_busy, rr_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_rr: outputs not all zero (addr=%h busy=%b)",
               rr_av_address, rr_busy);
    end
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_ifetch();
    sel_rr = 1'b0;
    apply_reset();
    run_round(1, 0, 0, 0, 0, 0, 32'hBFC0_0004, 32'h0, 0, 32'h0, 4'h0,
              32'h2402_000A, 32'h0);
  endtask

  task automatic test_data_write();
    run_round(0, 1, 0, 0, 1, 0, 32'h0, 32'h0000_2000, 0, 32'h0, 4'hF,
              32'h0, 32'h1234_5678);
    run_round(0, 1, 0, 0, 0, 3, 32'h0, 32'h0000_1003, 1, 32'hA500_0000, 4'b1000,
              32'h0, 32'hDEAD_BEEF);
  endtask

  task automatic test_priority();
    run_round(1, 1, 0, 0, 0, 0, 32'h0000_0100, 32'h0000_0200, 0, 32'h0, 4'h0,
              32'h1111_1111, 32'h2222_2222);
    run_round(1, 1, 0, 0, 2, 1, 32'h0000_0104, 32'h0000_0204, 1, 32'hCAFE_F00D, 4'b0011,
              32'h3333_3333, 32'h0);
  endtask

  task automatic test_round_robin();
    sel_rr = 1'b1;
    apply_reset();
    for (int r = 0; r < 3; r++)
      run_round(1, 1, 0, 0, r, 0, 32'h0000_0400 + 32'(r * 4), 32'h0000_0800 + 32'(r * 4),
                0, 32'h0, 4'h0, $urandom, $urandom);
  endtask

  task automatic test_watchdog();
    sel_rr = 1'b0;
    apply_reset();
    run_round(0, 1, 0, 0, 0, 0, 32'h0, 32'h0000_3000, 0, 32'h0, 4'h0, 32'h0, 32'h5555_AAAA);
    run_round(0, 1, 0, 0, 0, 20, 32'h0, 32'h0000_3004, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    run_round(1, 0, 0, 0, 20, 0, 32'h0000_0010, 32'h0, 0, 32'h0, 4'h0, 32'h0, 32'h0);
    run_round(1, 1, 0, 0, MAX_W, MAX_W + 1, 32'h0000_0014, 32'h0000_3008, 1,
              32'h0F0F_0F0F, 4'b0100, 32'h7777_7777, 32'h0);
  endtask

  task automatic test_reset_midflight();
    sel_rr = 1'b0;
    apply_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2008; d_wdata = 32'h0BAD_F00D;
    d_be = 4'hF; av_waitrequest = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (obs_av_write !== 1'b1) begin
      errors++;
      $display("FAIL midflight_pre: av_write got %b, want 1", obs_av_write);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({obs_av_write, obs_av_read, obs_busy, obs_d_ack} !== 4'b0) begin
      errors++;
      $display("FAIL midflight_async: write/read/busy/ack got %b, want 0000",
               {obs_av_write, obs_av_read, obs_busy, obs_d_ack});
    end
    @(posedge clk); #1;
    checks++;
    if ({obs_av_write, obs_busy, obs_d_ack} !== 3'b0) begin
      errors++;
      $display("FAIL midflight_held: write/busy/ack got %b, want 000",
               {obs_av_write, obs_busy, obs_d_ack});
    end
    d_req = 1'b0; av_waitrequest = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({obs_busy, obs_d_ack, obs_timeout} !== 3'b0) begin
        errors++;
        $display("FAIL midflight_after: busy/ack/err got %b, want 000",
                 {obs_busy, obs_d_ack, obs_timeout});
      end
    end
  endtask

  task automatic test_random(input bit rr, input int rounds);
    bit hi, hd;
    int ti, td, wi, wd;
    sel_rr = rr;
    apply_reset();
    for (int r = 0; r < rounds; r++) begin
      hi = 1'($urandom_range(0, 1));
      hd = 1'($urandom_range(0, 1));
      if (!hi && !hd) hd = 1'b1;
      ti = $urandom_range(0, 3);
      td = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        ti = 0; td = 0;
      end
      wi = ($urandom_range(0, 5) == 0) ? $urandom_range(MAX_W + 1, 9) : $urandom_range(0, MAX_W);
      wd = ($urandom_range(0, 5) == 0) ? $urandom_range(MAX_W + 1, 9) : $urandom_range(0, MAX_W);
      run_round(hi, hd, ti, td, wi, wd, $urandom, $urandom, 1'($urandom_range(0, 1)),
                $urandom, 4'($urandom_range(1, 15)), $urandom, $urandom);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ifetch();
    test_data_write();
    test_priority();
    test_round_robin();
    test_watchdog();
    test_reset_midflight();
    test_random(1'b0, 40);
    test_random(1'b1, 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
